life_event_scheduler: RTL and testbench
=======================================

# life_event_scheduler

Sequences all life-affecting game events into the lives counter. It takes raw bomb-hit, enemy-hit and life-kit pickup requests from the collision logic and issues clean single-cycle decrement and increment pulses. It enforces an invulnerability window after each hit, paces pickups to one per second, and runs the game-over sequence. It sits between the collision/pickup detectors and the lives counter; its `invulnerable`, `blink` and `game_over` outputs feed the player sprite, the audio controller and the top-level game FSM.

## Interface
- `INVULN_SECONDS`, default 2: length of the post-hit invulnerability window, in `OneSecPulse` periods. Legal range 1..15.
- `MAX_LIVES`, default 9: a pickup is discarded when `lives >= MAX_LIVES`.
- `PEND_MAX`, default 3: saturation value of the queued-pickup counter.
- `BLINK_PERIOD`, default 4_000_000: number of `clk` cycles per blink half-period. Used only with `LIFE_BLINK_EN`.
- `clk`, in, 1: system clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `OneSecPulse`, in, 1: one-cycle pulse once per second.
- `game_active`, in, 1: high while a round is running.
- `hit_bomb`, in, 1: level input; the player is inside an explosion.
- `hit_enemy`, in, 1: level input; the player is touching an enemy.
- `pickup_life`, in, 1: one-cycle pulse per life kit collected.
- `lives`, in, 4: current value from the lives counter.
- `decrement_life`, out, 1: one-cycle pulse to the counter.
- `increment_life`, out, 1: one-cycle pulse to the counter.
- `invulnerable`, out, 1: high in states HIT, SETTLE and INVULN.
- `blink`, out, 1: player sprite flicker enable.
- `game_over`, out, 1: high in state OVER.
- `hit_cause`, out, 2: cause of the last hit. 00 = none, 01 = bomb, 10 = enemy.

## Operation
- The FSM has five states: IDLE, HIT, SETTLE, INVULN, OVER. It resets to IDLE.
- **IDLE:** if `game_active` is high and (`hit_bomb` or `hit_enemy`) is high, go to HIT. `hit_cause` latches 01 if `hit_bomb` is high, otherwise 10 (bomb has priority).
- **HIT:** assert `decrement_life` for this one cycle. Always go to SETTLE.
- **SETTLE:** the counter has now updated.
  - If `lives == 0`, go to OVER.
  - Otherwise load `inv_cnt = INVULN_SECONDS` and go to INVULN.
- **INVULN:** hits are ignored. On each `OneSecPulse`, decrement `inv_cnt`. When a pulse arrives with `inv_cnt == 1`, go to IDLE. Pulses received during HIT or SETTLE are not counted.
- **OVER:** `game_over` is held high. All hits and pickups are ignored. Stay here until `game_active` goes low, then go to IDLE.
- **`game_active` low in any state:**
  - Next state is IDLE.
  - `pend` clears to 0.
  - `inc_armed` sets to 1.
  - `hit_cause` holds its value.
- **Pickup queue:**
  - Each `pickup_life` pulse, while `game_active` is high and the state is not OVER, adds 1 to `pend`, saturating at `PEND_MAX`. Extra pulses are lost.
- **Increment issue:**
  - Conditions: `pend > 0`, `inc_armed` is high, state is IDLE or INVULN, and no HIT transition is taking place this cycle.
  - If `lives < MAX_LIVES`: pulse `increment_life`, decrement `pend`, clear `inc_armed`.
  - Otherwise: decrement `pend` with no pulse (the pickup is discarded), and leave `inc_armed` unchanged.
- **`inc_armed`:** set on every `OneSecPulse`, and on reset. At most one increment is issued per pulse window, because the downstream counter accepts only one per window.
- **Same-cycle pickup:** a pickup pulse in the same cycle as an increment issue is counted; `pend` updates by +1 −1 = net 0.
- **Same-cycle events:** a hit and a pickup in the same cycle: the hit goes to HIT and the pickup is queued. `decrement_life` and `increment_life` are never high in the same cycle.
- **Width rules:** `pend` is 2 bits. `inv_cnt` is 4 bits. The `lives` comparisons are unsigned.

## Timing
- **Reset values:** all outputs 0, `hit_cause` = 00, `pend` = 0, `inv_cnt` = 0, `inc_armed` = 1, blink timer = 0, state IDLE.
- **Latency:**
  - A hit sampled high at edge N gives `decrement_life` high during cycle N+1.
  - The SETTLE decision is made at edge N+2.
  - `invulnerable` is high from cycle N+1.
- **Invulnerability length:** from entry to INVULN until the `INVULN_SECONDS`-th pulse after entry, inclusive.
- **Return to IDLE:** the FSM returns to IDLE on the edge where that final pulse is sampled. A hit held high in that same cycle is ignored; it is taken on the next cycle if still high.
- **Increment latency:** `increment_life` asserts one cycle after the conditions are met.
- **Reset mid-operation:** reset takes effect immediately and asynchronously; any pulse in flight is dropped.

## Configuration
- **`LIFE_BLINK_EN` defined:** a `clk` counter toggles `blink` every `BLINK_PERIOD` cycles while `invulnerable` is high.
  - The counter and `blink` are cleared on entry to HIT.
  - `blink` is forced to 0 outside HIT, SETTLE and INVULN.
- **`LIFE_BLINK_EN` undefined:** `blink` is tied to 0 and no blink counter is synthesized.

## Test plan
- **Single hit:** `lives` = 3, `hit_enemy` high for 1 cycle → one `decrement_life` pulse one cycle later; `hit_cause` = 10; `invulnerable` high until the 2nd `OneSecPulse`.
- **Held bomb hit:** `hit_bomb` held high for 3 s, `INVULN_SECONDS` = 2 → exactly 2 `decrement_life` pulses, spaced by the invulnerability window; `hit_cause` = 01.
- **Final life:** `lives` = 1, hit; bench counter goes to 0 → FSM goes SETTLE→OVER; `game_over` = 1; later hits and pickups ignored; `game_active` low → IDLE, `game_over` = 0.
- **Pickup pacing:** 4 `pickup_life` pulses in 10 cycles → `pend` saturates at 3; `increment_life` pulses 3 times, one per `OneSecPulse` window.
- **Pickups at the limit:** `lives` = `MAX_LIVES` with 2 pickups queued → no `increment_life` pulse; `pend` goes to 0.
- **Simultaneous events:** hit and pickup in the same cycle → `decrement_life` first, pickup queued and issued later, never in the same cycle as a decrement. Also assert `resetN` mid-INVULN → all outputs 0 immediately.

Source files
------------

// File: rtl/life_event_scheduler.sv
// life_event_scheduler
// Sequences hit and pickup requests into single-cycle decrement/increment
// pulses for the lives counter. Holds a post-hit invulnerability window,
// paces pickups to one increment per OneSecPulse window and parks in a
// game-over state until the round ends.
// Optional feature macro: LIFE_BLINK_EN builds the sprite blink timer;
// without it blink is tied low and no timer exists.
module life_event_scheduler #(
  parameter int INVULN_SECONDS = 2,
  parameter int MAX_LIVES      = 9,
  parameter int PEND_MAX       = 3,
  parameter int BLINK_PERIOD   = 4_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       OneSecPulse,
  input  logic       game_active,
  input  logic       hit_bomb,
  input  logic       hit_enemy,
  input  logic       pickup_life,
  input  logic [3:0] lives,
  output logic       decrement_life,
  output logic       increment_life,
  output logic       invulnerable,
  output logic       blink,
  output logic       game_over,
  output logic [1:0] hit_cause
);

  typedef enum logic [2:0] {IDLE, HIT, SETTLE, INVULN, OVER} state_t;

  localparam logic [3:0] InvSecs  = 4'(INVULN_SECONDS);
  localparam logic [4:0] MaxLives = 5'(MAX_LIVES);
  localparam logic [2:0] PendMax  = 3'(PEND_MAX);

  if (INVULN_SECONDS < 1 || INVULN_SECONDS > 15 || PEND_MAX < 1 || PEND_MAX > 3 ||
      BLINK_PERIOD < 1) begin : g_param_check
    $error("life_event_scheduler: parameter out of legal range");
  end

  state_t     state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [3:0] inv_cnt_q, inv_cnt_d;
  logic       armed_q, armed_d;
  logic       inc_q, inc_d;
  logic [1:0] cause_q, cause_d;
  logic [2:0] pend_sum;

  logic hit_req, hit_take, pick_acc, issue, room;

  // A hit is only taken from IDLE; the pickup queue is closed in OVER.
  assign hit_req  = game_active & (hit_bomb | hit_enemy);
  assign hit_take = hit_req & (state_q == IDLE);
  assign pick_acc = pickup_life & game_active & (state_q != OVER);
  assign issue    = game_active & (pend_q != 2'd0) & armed_q &
                    ((state_q == IDLE) | (state_q == INVULN)) & ~hit_take;
  assign room     = {1'b0, lives} < MaxLives;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; dropping game_active always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!game_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (hit_req) state_d = HIT;
        HIT:     state_d = SETTLE;
        SETTLE:  state_d = (lives == 4'd0) ? OVER : INVULN;
        INVULN:  if (OneSecPulse && inv_cnt_q == 4'd1) state_d = IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    decrement_life = (state_q == HIT);
    invulnerable   = (state_q == HIT) || (state_q == SETTLE) || (state_q == INVULN);
    game_over      = (state_q == OVER);
  end

  assign increment_life = inc_q;
  assign hit_cause      = cause_q;

  // Pickup queue, increment pacing, invulnerability countdown and hit cause
  always_comb begin
    pend_d    = pend_q;
    inv_cnt_d = inv_cnt_q;
    armed_d   = armed_q;
    cause_d   = cause_q;
    inc_d     = issue & room;
    // add before clamping so a full queue with a same-cycle issue stays full
    pend_sum  = {1'b0, pend_q} + {2'b00, pick_acc} - {2'b00, issue};

    if (hit_take) cause_d = hit_bomb ? 2'b01 : 2'b10;

    if (state_q == SETTLE && state_d == INVULN) begin
      inv_cnt_d = InvSecs;
    end else if (state_q == INVULN && OneSecPulse) begin
      inv_cnt_d = inv_cnt_q - 4'd1;
    end

    if (!game_active) begin
      pend_d  = 2'd0;
      armed_d = 1'b1;
    end else begin
      pend_d = (pend_sum > PendMax) ? PendMax[1:0] : pend_sum[1:0];
      // an issued increment consumes the window even if a pulse lands now
      if (issue && room)    armed_d = 1'b0;
      else if (OneSecPulse) armed_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_q    <= 2'd0;
      inv_cnt_q <= 4'd0;
      armed_q   <= 1'b1;
      inc_q     <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      pend_q    <= pend_d;
      inv_cnt_q <= inv_cnt_d;
      armed_q   <= armed_d;
      inc_q     <= inc_d;
      cause_q   <= cause_d;
    end
  end

`ifdef LIFE_BLINK_EN
  localparam logic [31:0] BlinkLast = 32'(BLINK_PERIOD - 1);

  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q, blink_d;

  // Blink timer restarts on each new hit and toggles every BLINK_PERIOD cycles
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (hit_take) begin
      blink_cnt_d = 32'd0;
      blink_d     = 1'b0;
    end else if (invulnerable) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = 32'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
      end
    end else begin
      blink_cnt_d = 32'd0;
      blink_d     = 1'b0;
    end
  end

  // Blink timer registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q <= 32'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q & invulnerable;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_life_event_scheduler.sv
// Testbench for life_event_scheduler: directed scenarios plus a randomized
// run, all compared against a behavioural model of the game rules. The bench
// plays the role of the lives counter and the one-second tick generator.
`timescale 1ns/1ps
module tb_life_event_scheduler;

  localparam int INV_S   = 2;
  localparam int MAXL    = 9;
  localparam int PMAX    = 3;
  localparam int SEC_CYC = 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       OneSecPulse = 1'b0;
  logic       game_active = 1'b0;
  logic       hit_bomb = 1'b0;
  logic       hit_enemy = 1'b0;
  logic       pickup_life = 1'b0;
  logic [3:0] lives = 4'd3;
  logic       decrement_life, increment_life, invulnerable, blink, game_over;
  logic [1:0] hit_cause;
  logic [6:0] got;

  int checks = 0;
  int fails  = 0;
  int sec_cnt = 0;

  life_event_scheduler #(
    .INVULN_SECONDS(INV_S), .MAX_LIVES(MAXL), .PEND_MAX(PMAX), .BLINK_PERIOD(4)
  ) dut (
    .clk(clk), .resetN(resetN), .OneSecPulse(OneSecPulse), .game_active(game_active),
    .hit_bomb(hit_bomb), .hit_enemy(hit_enemy), .pickup_life(pickup_life), .lives(lives),
    .decrement_life(decrement_life), .increment_life(increment_life),
    .invulnerable(invulnerable), .blink(blink), .game_over(game_over), .hit_cause(hit_cause)
  );

  assign got = {decrement_life, increment_life, invulnerable, blink, game_over, hit_cause};

  always #5 clk = ~clk;

  // ---------------- behavioural model of the game rules ----------------
  typedef enum int {M_IDLE, M_HIT, M_SETTLE, M_INV, M_OVER} mphase_t;
  mphase_t    m_ph = M_IDLE;
  int         m_pend = 0;     // queued pickups
  int         m_left = 0;     // seconds of protection left
  bit         m_armed = 1'b1; // one increment allowed in this second
  bit         m_inc = 1'b0;   // increment pulse currently expected
  logic [1:0] m_cause = 2'b00;

  task automatic model_reset();
    m_ph = M_IDLE; m_pend = 0; m_left = 0; m_armed = 1'b1; m_inc = 1'b0; m_cause = 2'b00;
  endtask

  // Apply one clock's worth of game rules to the inputs seen at that edge.
  task automatic model_step();
    bit took_hit, may_issue, has_room;
    int q;
    took_hit  = game_active && (hit_bomb || hit_enemy) && m_ph == M_IDLE;
    has_room  = int'(lives) < MAXL;
    may_issue = game_active && m_pend > 0 && m_armed && !took_hit &&
                (m_ph == M_IDLE || m_ph == M_INV);
    m_inc = may_issue && has_room;
    if (!game_active) begin
      m_ph = M_IDLE; m_pend = 0; m_armed = 1'b1;
      return;
    end
    q = m_pend;
    if (pickup_life && m_ph != M_OVER) q = q + 1;
    if (may_issue) q = q - 1;
    m_pend = (q > PMAX) ? PMAX : q;
    if (may_issue && has_room) m_armed = 1'b0;
    else if (OneSecPulse) m_armed = 1'b1;
    if (took_hit) m_cause = hit_bomb ? 2'b01 : 2'b10;
    case (m_ph)
      M_IDLE:   if (took_hit) m_ph = M_HIT;
      M_HIT:    m_ph = M_SETTLE;
      M_SETTLE: if (lives == 4'd0) m_ph = M_OVER; else begin m_ph = M_INV; m_left = INV_S; end
      M_INV:    if (OneSecPulse) begin
                  if (m_left == 1) m_ph = M_IDLE;
                  m_left = m_left - 1;
                end
      default:  ;
    endcase
  endtask

  function automatic logic [6:0] expected();
    logic prot;
    prot = (m_ph == M_HIT) || (m_ph == M_SETTLE) || (m_ph == M_INV);
    return {m_ph == M_HIT, m_inc, prot, 1'b0, m_ph == M_OVER, m_cause};
  endfunction

  // One clock: advance the model, let the DUT see the edge, then play the
  // lives counter and the one-second tick generator.
  task automatic tick();
    int d, i, l;
    d = (m_ph == M_HIT) ? 1 : 0;
    i = m_inc ? 1 : 0;
    if (resetN) model_step(); else model_reset();
    @(posedge clk);
    #1;
    l = int'(lives) - d + i;
    if (l < 0) l = 0;
    if (l > 15) l = 15;
    lives = 4'(l);
    sec_cnt++;
    OneSecPulse = (sec_cnt % SEC_CYC == 0);
  endtask

  task automatic quiesce(input logic [3:0] l);
    game_active = 1'b0; hit_bomb = 1'b0; hit_enemy = 1'b0; pickup_life = 1'b0;
    repeat (2) tick();
    lives = l; game_active = 1'b1; sec_cnt = 0; OneSecPulse = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetN = 1'b0; game_active = 1'b1; hit_bomb = 1'b1; pickup_life = 1'b1;
    repeat (3) tick();
    checks++;
    if (got !== 7'b0) begin fails++; $display("FAIL reset_outputs: got %b want %b", got, 7'b0); end
    hit_bomb = 1'b0; pickup_life = 1'b0; game_active = 1'b0;
    resetN = 1'b1;
    tick();
    checks++;
    if (got !== 7'b0) begin fails++; $display("FAIL reset_release: got %b want %b", got, 7'b0); end
    // increment is armed straight out of reset
    game_active = 1'b1; lives = 4'd3; pickup_life = 1'b1;
    tick();
    pickup_life = 1'b0;
    tick();
    checks++;
    if (increment_life !== 1'b1) begin fails++; $display("FAIL reset_armed: inc %b want 1", increment_life); end
    checks++;
    if (got !== expected()) begin fails++; $display("FAIL reset_model: got %b want %b", got, expected()); end
  endtask

  task automatic test_single_hit();
    int ndec, ninv;
    ndec = 0; ninv = 0;
    quiesce(4'd3);
    hit_enemy = 1'b1;
    tick();
    hit_enemy = 1'b0;
    checks++;
    if (decrement_life !== 1'b1) begin fails++; $display("FAIL single_hit_latency: dec %b want 1", decrement_life); end
    for (int c = 0; c < 60; c++) begin
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL single_hit cyc %0d: got %b want %b", c, got, expected()); end
      if (decrement_life) ndec++;
      if (invulnerable) ninv++;
      tick();
    end
    checks++;
    if (ndec != 1) begin fails++; $display("FAIL single_hit_count: dec pulses %0d want 1", ndec); end
    checks++;
    if (ninv != 32) begin fails++; $display("FAIL single_hit_window: invulnerable cycles %0d want 32", ninv); end
    checks++;
    if (hit_cause !== 2'b10) begin fails++; $display("FAIL single_hit_cause: got %b want 10", hit_cause); end
  endtask

  task automatic test_held_bomb();
    int ndec, first, second;
    ndec = 0; first = 0; second = 0;
    quiesce(4'd5);
    hit_bomb = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (e == 48) hit_bomb = 1'b0;
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL held_bomb edge %0d: got %b want %b", e, got, expected()); end
      if (decrement_life) begin
        if (ndec == 0) first = e; else second = e;
        ndec++;
      end
    end
    checks++;
    if (ndec != 2) begin fails++; $display("FAIL held_bomb_count: dec pulses %0d want 2", ndec); end
    checks++;
    if (second - first != 33) begin fails++; $display("FAIL held_bomb_spacing: gap %0d want 33", second - first); end
    checks++;
    if (hit_cause !== 2'b01) begin fails++; $display("FAIL held_bomb_cause: got %b want 01", hit_cause); end
  endtask

  task automatic test_final_life();
    int nev;
    nev = 0;
    quiesce(4'd1);
    hit_enemy = 1'b1;
    tick();
    hit_enemy = 1'b0;
    for (int e = 2; e <= 40; e++) begin
      tick();
      hit_bomb    = ($urandom_range(0, 1) == 1);
      pickup_life = (e % 3 == 0);
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL final_life edge %0d: got %b want %b", e, got, expected()); end
      if (e >= 3 && game_over !== 1'b1) begin
        fails++; $display("FAIL final_life_over edge %0d: game_over %b want 1", e, game_over);
      end
      if (decrement_life || increment_life) nev++;
    end
    checks++;
    if (nev != 0) begin fails++; $display("FAIL final_life_ignored: %0d pulses want 0", nev); end
    hit_bomb = 1'b0; pickup_life = 1'b0; game_active = 1'b0;
    tick();
    checks++;
    if (game_over !== 1'b0) begin fails++; $display("FAIL final_life_exit: game_over %b want 0", game_over); end
    checks++;
    if (hit_cause !== 2'b10) begin fails++; $display("FAIL final_life_cause_hold: got %b want 10", hit_cause); end
  endtask

  task automatic test_pickup_pacing();
    int ninc, last, badgap;
    ninc = 0; last = 0; badgap = 0;
    quiesce(4'd3);
    pickup_life = 1'b1;
    tick();
    pickup_life = 1'b0;
    tick();
    checks++;
    if (increment_life !== 1'b1) begin fails++; $display("FAIL pacing_first: inc %b want 1", increment_life); end
    last = 2;
    for (int e = 3; e <= 60; e++) begin
      pickup_life = (e == 3 || e == 5 || e == 7 || e == 9);
      tick();
      pickup_life = 1'b0;
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL pacing edge %0d: got %b want %b", e, got, expected()); end
      if (increment_life) begin
        if (e - last != SEC_CYC) badgap++;
        last = e;
        ninc++;
      end
    end
    checks++;
    if (ninc != 3) begin fails++; $display("FAIL pacing_count: inc pulses %0d want 3", ninc); end
    checks++;
    if (badgap != 0) begin fails++; $display("FAIL pacing_spacing: %0d gaps not %0d cycles", badgap, SEC_CYC); end
  endtask

  task automatic test_pickups_at_limit();
    int ninc;
    ninc = 0;
    quiesce(4'(MAXL));
    for (int e = 1; e <= 30; e++) begin
      pickup_life = (e == 1 || e == 2);
      tick();
      pickup_life = 1'b0;
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL limit edge %0d: got %b want %b", e, got, expected()); end
      if (increment_life) ninc++;
    end
    checks++;
    if (ninc != 0) begin fails++; $display("FAIL limit_no_inc: inc pulses %0d want 0", ninc); end
    lives = 4'd5;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (increment_life) ninc++;
    end
    checks++;
    if (ninc != 0) begin fails++; $display("FAIL limit_drained: inc pulses %0d want 0", ninc); end
  endtask

  task automatic test_simultaneous();
    int dec_e, inc_e, both;
    dec_e = 0; inc_e = 0; both = 0;
    quiesce(4'd5);
    hit_enemy = 1'b1; pickup_life = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      hit_enemy = 1'b0; pickup_life = 1'b0;
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL simul edge %0d: got %b want %b", e, got, expected()); end
      if (decrement_life && dec_e == 0) dec_e = e;
      if (increment_life && inc_e == 0) inc_e = e;
      if (decrement_life && increment_life) both++;
    end
    checks++;
    if (dec_e != 1 || inc_e != 4) begin
      fails++; $display("FAIL simul_order: dec at %0d inc at %0d want 1 and 4", dec_e, inc_e);
    end
    checks++;
    if (both != 0) begin fails++; $display("FAIL simul_overlap: %0d shared cycles want 0", both); end
    checks++;
    if (invulnerable !== 1'b1) begin fails++; $display("FAIL simul_in_invuln: invulnerable %b want 1", invulnerable); end
    #3;
    resetN = 1'b0;
    model_reset();
    #1;
    checks++;
    if (got !== 7'b0) begin fails++; $display("FAIL async_reset: got %b want %b", got, 7'b0); end
    tick();
    tick();
    resetN = 1'b1;
    tick();
    checks++;
    if (got !== expected()) begin fails++; $display("FAIL reset_recover: got %b want %b", got, expected()); end
  endtask

  task automatic test_random();
    quiesce(4'd3);
    for (int c = 0; c < 800; c++) begin
      hit_bomb    = ($urandom_range(0, 24) == 0);
      hit_enemy   = ($urandom_range(0, 19) == 0);
      pickup_life = ($urandom_range(0, 5) == 0);
      if (!game_active) begin
        game_active = 1'b1;
      end else if ($urandom_range(0, 99) == 0 || (m_ph == M_OVER && $urandom_range(0, 7) == 0)) begin
        game_active = 1'b0;
        lives = 4'($urandom_range(0, 12));
      end
      tick();
      checks++;
      if (got !== expected()) begin fails++; $display("FAIL random cyc %0d: got %b want %b", c, got, expected()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_held_bomb();
    test_final_life();
    test_pickup_pacing();
    test_pickups_at_limit();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
